// File: rtl/sap1_controller_sequencer_pkg.sv
// Shared SAP-1 sequencer definitions: opcode and T-state encodings plus the control-word layout.
package sap1_controller_sequencer_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'b0000,
    OP_ADD = 4'b0001,
    OP_SUB = 4'b0010,
    OP_OUT = 4'b1110,
    OP_HLT = 4'b1111
  } op_e;

  // One-hot T-states; bit0 is T1 so the state value doubles as the ring counter output.
  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_t;

endpackage

// File: rtl/sap1_ring_counter.sv
// Negedge one-hot T-state rotator with asynchronous active-low clear and a hold input.
module sap1_ring_counter
  import sap1_controller_sequencer_pkg::*;
#(
  parameter int unsigned RING_W = 6
) (
  input  logic              CLK,
  input  logic              CLR_n,
  input  logic              i_hold,
  output logic [RING_W-1:0] o_tstate
);

  tstate_e r_state;
  tstate_e w_next;

  always_ff @(negedge CLK or negedge CLR_n) begin
    if (!CLR_n) r_state <= T1;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!i_hold) begin
      unique case (r_state)
        T1:      w_next = T2;
        T2:      w_next = T3;
        T3:      w_next = T4;
        T4:      w_next = T5;
        T5:      w_next = T6;
        T6:      w_next = T1;
        default: w_next = T1;
      endcase
    end
  end

  assign o_tstate = r_state;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter, sticky halt flop and combinational control-word decode.
module sap1_controller_sequencer
  import sap1_controller_sequencer_pkg::*;
#(
  parameter int unsigned OP_W   = 4,
  parameter int unsigned RING_W = 6
) (
  input  logic              CLK,
  input  logic              CLR_n,
  input  logic [OP_W-1:0]   opcode,
  output logic              Cp,
  output logic              Ep,
  output logic              Lm,
  output logic              CE,
  output logic              Li,
  output logic              Ei,
  output logic              La,
  output logic              Ea,
  output logic              Su,
  output logic              Eu,
  output logic              Lb,
  output logic              Lo,
  output logic              Hlt,
  output logic [RING_W-1:0] tstate
);

  logic              r_halted;
  logic              w_hlt_now;
  logic [RING_W-1:0] w_tstate;
  ctrl_t             w_cw;

  // Freeze the ring on the same edge that sets the halt flop so T4 is held, not T5.
  assign w_hlt_now = (w_tstate == T4) && (opcode == OP_HLT);

  sap1_ring_counter #(
    .RING_W (RING_W)
  ) u_ring (
    .CLK      (CLK),
    .CLR_n    (CLR_n),
    .i_hold   (r_halted | w_hlt_now),
    .o_tstate (w_tstate)
  );

  always_ff @(negedge CLK or negedge CLR_n) begin
    if (!CLR_n)         r_halted <= 1'b0;
    else if (w_hlt_now) r_halted <= 1'b1;
  end

  always_comb begin
    w_cw = '0;
    if (!r_halted) begin
      case (w_tstate)
        T1: begin
          w_cw.ep = 1'b1;
          w_cw.lm = 1'b1;
        end
        T2: w_cw.cp = 1'b1;
        T3: begin
          w_cw.ce = 1'b1;
          w_cw.li = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              w_cw.ei = 1'b1;
              w_cw.lm = 1'b1;
            end
            OP_OUT: begin
              w_cw.ea = 1'b1;
              w_cw.lo = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              w_cw.ce = 1'b1;
              w_cw.la = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              w_cw.ce = 1'b1;
              w_cw.lb = 1'b1;
            end
            default: ;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD: begin
              w_cw.eu = 1'b1;
              w_cw.la = 1'b1;
            end
            OP_SUB: begin
              w_cw.su = 1'b1;
              w_cw.eu = 1'b1;
              w_cw.la = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign Cp     = w_cw.cp;
  assign Ep     = w_cw.ep;
  assign Lm     = w_cw.lm;
  assign CE     = w_cw.ce;
  assign Li     = w_cw.li;
  assign Ei     = w_cw.ei;
  assign La     = w_cw.la;
  assign Ea     = w_cw.ea;
  assign Su     = w_cw.su;
  assign Eu     = w_cw.eu;
  assign Lb     = w_cw.lb;
  assign Lo     = w_cw.lo;
  assign Hlt    = r_halted;
  assign tstate = w_tstate;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Directed, table-driven bench for the SAP-1 controller-sequencer.
module tb_sap1_controller_sequencer;

  logic       CLK = 1'b0;
  logic       CLR_n = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo, Hlt;
  logic [5:0] tstate;
  logic [11:0] cw;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Control word order: {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
  localparam logic [11:0] W_NONE = 12'h000;
  localparam logic [11:0] W_T1   = 12'h600;
  localparam logic [11:0] W_T2   = 12'h800;
  localparam logic [11:0] W_T3   = 12'h180;
  localparam logic [11:0] W_MEM4 = 12'h240;
  localparam logic [11:0] W_OUT4 = 12'h011;
  localparam logic [11:0] W_LDA5 = 12'h120;
  localparam logic [11:0] W_AB5  = 12'h102;
  localparam logic [11:0] W_ADD6 = 12'h024;
  localparam logic [11:0] W_SUB6 = 12'h02C;

  localparam logic [5:0] S1 = 6'b000001, S2 = 6'b000010, S3 = 6'b000100,
                         S4 = 6'b001000, S5 = 6'b010000, S6 = 6'b100000;

  typedef struct {
    logic [3:0]  op;
    logic [5:0]  t;
    logic [11:0] cw;
    string       name;
  } vec_t;

  vec_t vecs[$];

  sap1_controller_sequencer #(
    .OP_W   (4),
    .RING_W (6)
  ) dut (
    .CLK    (CLK),
    .CLR_n  (CLR_n),
    .opcode (opcode),
    .Cp     (Cp),
    .Ep     (Ep),
    .Lm     (Lm),
    .CE     (CE),
    .Li     (Li),
    .Ei     (Ei),
    .La     (La),
    .Ea     (Ea),
    .Su     (Su),
    .Eu     (Eu),
    .Lb     (Lb),
    .Lo     (Lo),
    .Hlt    (Hlt),
    .tstate (tstate)
  );

  assign cw = {Cp, Ep, Lm, CE, Li, Ei, La, Ea, Su, Eu, Lb, Lo};

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [5:0] et,
                       input logic [11:0] ecw, input logic eh);
    n_vec++;
    if (tstate !== et || cw !== ecw || Hlt !== eh) begin
      n_err++;
      $display("FAIL %s: got tstate=%b cw=%h Hlt=%b, expected tstate=%b cw=%h Hlt=%b",
               name, tstate, cw, Hlt, et, ecw, eh);
    end
  endtask

  task automatic step(input logic [3:0] op);
    opcode = op;
    @(negedge CLK);
    #1;
  endtask

  task automatic add(input logic [3:0] op, input logic [5:0] t,
                     input logic [11:0] w, input string name);
    vecs.push_back('{op: op, t: t, cw: w, name: name});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, expected completion", $time);
    $fatal(1);
  end

  initial begin
    // Fetch opcodes are deliberately junk: decode must ignore them outside T4-T6.
    add(4'hF, S2, W_T2,   "lda_t2");   add(4'h1, S3, W_T3,   "lda_t3");
    add(4'h0, S4, W_MEM4, "lda_t4");   add(4'h0, S5, W_LDA5, "lda_t5");
    add(4'h0, S6, W_NONE, "lda_t6");   add(4'h0, S1, W_T1,   "lda_wrap");
    add(4'hE, S2, W_T2,   "add_t2");   add(4'h2, S3, W_T3,   "add_t3");
    add(4'h1, S4, W_MEM4, "add_t4");   add(4'h1, S5, W_AB5,  "add_t5");
    add(4'h1, S6, W_ADD6, "add_t6");   add(4'h2, S1, W_T1,   "add_wrap");
    add(4'h2, S2, W_T2,   "sub_t2");   add(4'h2, S3, W_T3,   "sub_t3");
    add(4'h2, S4, W_MEM4, "sub_t4");   add(4'h2, S5, W_AB5,  "sub_t5");
    add(4'h2, S6, W_SUB6, "sub_t6");   add(4'h2, S1, W_T1,   "sub_wrap");
    add(4'hE, S2, W_T2,   "out_t2");   add(4'hE, S3, W_T3,   "out_t3");
    add(4'hE, S4, W_OUT4, "out_t4");   add(4'hE, S5, W_NONE, "out_t5");
    add(4'hE, S6, W_NONE, "out_t6");   add(4'h5, S1, W_T1,   "out_wrap");
    add(4'h5, S2, W_T2,   "nop_t2");   add(4'h5, S3, W_T3,   "nop_t3");
    add(4'h5, S4, W_NONE, "nop_t4");   add(4'h5, S5, W_NONE, "nop_t5");
    add(4'h5, S6, W_NONE, "nop_t6");   add(4'h5, S1, W_T1,   "nop_wrap");

    // Reset asserted from time 0; check asynchronously mid-cycle.
    #13;
    check("reset_async", S1, W_T1, 1'b0);
    @(negedge CLK); #1;
    check("reset_held", S1, W_T1, 1'b0);
    CLR_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].op);
      check(vecs[i].name, vecs[i].t, vecs[i].cw, 1'b0);
    end

    // HLT: freeze at T4 with all controls low until reset.
    step(4'hF); check("hlt_t2", S2, W_T2, 1'b0);
    step(4'hF); check("hlt_t3", S3, W_T3, 1'b0);
    step(4'hF); check("hlt_t4", S4, W_NONE, 1'b0);
    step(4'hF); check("hlt_set", S4, W_NONE, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step((i % 2 == 0) ? 4'h1 : 4'hE);
      check("hlt_frozen", S4, W_NONE, 1'b1);
    end
    #2 CLR_n = 1'b0;
    #1 check("hlt_clear", S1, W_T1, 1'b0);
    #2 CLR_n = 1'b1;
    step(4'h0); check("post_hlt_t2", S2, W_T2, 1'b0);

    // Mid-instruction reset during ADD T5.
    step(4'h1); check("abort_t3", S3, W_T3, 1'b0);
    step(4'h1); check("abort_t4", S4, W_MEM4, 1'b0);
    step(4'h1); check("abort_t5", S5, W_AB5, 1'b0);
    #2 CLR_n = 1'b0;
    #1 check("abort_async", S1, W_T1, 1'b0);
    @(negedge CLK); #1;
    check("abort_held", S1, W_T1, 1'b0);
    CLR_n = 1'b1;
    step(4'h1); check("abort_refetch_t2", S2, W_T2, 1'b0);
    step(4'h1); check("abort_refetch_t3", S3, W_T3, 1'b0);
    step(4'h1); check("abort_refetch_t4", S4, W_MEM4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
